// File: rtl/clk_enable_scheduler.sv
// Clock-enable tick generator: one shared prescaler drives NCH programmable channels.
// Channel reconfiguration is deferred to the channel's terminal count when it is running.
module clk_enable_scheduler #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CW       = 2,
    parameter int unsigned W        = 26,
    parameter int unsigned PRESCALE = 50,
    parameter int unsigned PW       = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [W-1:0]   cfg_period,
    input  logic           cfg_enable,
    output logic [NCH-1:0] ch_tick,
    output logic [NCH-1:0] ch_level
);

    localparam int unsigned PLAST = PRESCALE - 1;

    // Prescaler state
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_d;
    logic          base_tick;

    // Per-channel state
    logic [W-1:0]   cnt       [NCH];
    logic [W-1:0]   period    [NCH];
    logic [W-1:0]   sh_period [NCH];
    logic [NCH-1:0] en;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] sh_en;

    logic [W-1:0]   cnt_d       [NCH];
    logic [W-1:0]   period_d    [NCH];
    logic [W-1:0]   sh_period_d [NCH];
    logic [NCH-1:0] en_d;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] sh_en_d;
    logic [NCH-1:0] tick_d;
    logic [NCH-1:0] level_d;

    logic           xfer;
    logic [NCH-1:0] hit;

    // Base tick marks the last cycle of each prescaler period
    always_comb begin
        base_tick = (pcnt == PW'(PLAST));
        pcnt_d    = base_tick ? '0 : pcnt + PW'(1);
    end

    // Ready reflects only the addressed channel's pending flag; unknown channels always accept
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CW'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    always_comb begin
        xfer = cfg_valid & cfg_ready;
        hit  = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i] = xfer && (cfg_ch == CW'(i));
        end
    end

    // Channel next-state: count/wrap first, then the config transfer judged on pre-edge en
    always_comb begin
        cnt_d       = cnt;
        period_d    = period;
        sh_period_d = sh_period;
        en_d        = en;
        pend_d      = pend;
        sh_en_d     = sh_en;
        tick_d      = '0;
        level_d     = ch_level;

        for (int i = 0; i < NCH; i++) begin
            if (en[i] && base_tick) begin
                if (cnt[i] == period[i]) begin
                    tick_d[i]  = 1'b1;
                    level_d[i] = ~ch_level[i];
                    cnt_d[i]   = '0;
                    if (pend[i]) begin
                        period_d[i] = sh_period[i];
                        en_d[i]     = sh_en[i];
                        pend_d[i]   = 1'b0;
                        if (!sh_en[i]) begin
                            level_d[i] = 1'b0;
                        end
                    end
                end else begin
                    cnt_d[i] = cnt[i] + W'(1);
                end
            end

            if (hit[i]) begin
                if (!en[i]) begin
                    period_d[i] = cfg_period;
                    en_d[i]     = cfg_enable;
                    cnt_d[i]    = '0;
                    level_d[i]  = 1'b0;
                end else begin
                    sh_period_d[i] = cfg_period;
                    sh_en_d[i]     = cfg_enable;
                    pend_d[i]      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt     <= '0;
            en       <= '0;
            pend     <= '0;
            sh_en    <= '0;
            ch_tick  <= '0;
            ch_level <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]       <= '0;
                period[i]    <= '0;
                sh_period[i] <= '0;
            end
        end else begin
            pcnt     <= pcnt_d;
            en       <= en_d;
            pend     <= pend_d;
            sh_en    <= sh_en_d;
            ch_tick  <= tick_d;
            ch_level <= level_d;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]       <= cnt_d[i];
                period[i]    <= period_d[i];
                sh_period[i] <= sh_period_d[i];
            end
        end
    end

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Scoreboard bench for clk_enable_scheduler: a behavioural channel model predicts
// tick/level/ready every cycle; independent monitors pop and compare.
module tb_clk_enable_scheduler;

    localparam int NCH      = 4;
    localparam int CW       = 2;
    localparam int W        = 8;
    localparam int PRESCALE = 4;
    localparam int PW       = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_ch = '0;
    logic [W-1:0]   cfg_period = '0;
    logic           cfg_enable = 1'b0;
    logic [NCH-1:0] ch_tick;
    logic [NCH-1:0] ch_level;

    clk_enable_scheduler #(
        .NCH(NCH), .CW(CW), .W(W), .PRESCALE(PRESCALE), .PW(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_period(cfg_period),
        .cfg_enable(cfg_enable),
        .ch_tick(ch_tick),
        .ch_level(ch_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: base ticks remaining until each channel's next tick
    int m_cyc;
    int m_left [NCH];
    int m_per  [NCH];
    int m_sh   [NCH];
    bit m_en   [NCH];
    bit m_pend [NCH];
    bit m_shen [NCH];
    bit m_lvl  [NCH];
    bit m_tick [NCH];

    logic [2*NCH-1:0] q_out [$];
    bit               q_rdy [$];
    int               seen  [NCH];

    function void check(string nm, int unsigned act, int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    function void model_reset();
        m_cyc = 0;
        for (int i = 0; i < NCH; i++) begin
            m_left[i] = 0; m_per[i] = 0; m_sh[i] = 0;
            m_en[i] = 0; m_pend[i] = 0; m_shen[i] = 0;
            m_lvl[i] = 0; m_tick[i] = 0;
        end
    endfunction

    function bit model_ready(int ch);
        return (ch >= NCH) || !m_pend[ch];
    endfunction

    function void model_step(bit r, bit v, int ch, int per, bit en);
        bit bt;
        bit xfer;
        bit en_pre;
        if (r) begin
            model_reset();
            return;
        end
        bt   = (m_cyc % PRESCALE) == PRESCALE - 1;
        m_cyc++;
        xfer = v && model_ready(ch);
        for (int i = 0; i < NCH; i++) begin
            en_pre    = m_en[i];
            m_tick[i] = 0;
            if (en_pre && bt) begin
                if (m_left[i] == 0) begin
                    m_tick[i] = 1;
                    m_lvl[i]  = !m_lvl[i];
                    m_left[i] = m_per[i];
                    if (m_pend[i]) begin
                        m_per[i]  = m_sh[i];
                        m_left[i] = m_sh[i];
                        m_en[i]   = m_shen[i];
                        m_pend[i] = 0;
                        if (!m_shen[i]) m_lvl[i] = 0;
                    end
                end else begin
                    m_left[i]--;
                end
            end
            if (xfer && ch == i) begin
                if (!en_pre) begin
                    m_per[i]  = per;
                    m_left[i] = per;
                    m_en[i]   = en;
                    m_lvl[i]  = 0;
                end else begin
                    m_sh[i]   = per;
                    m_shen[i] = en;
                    m_pend[i] = 1;
                end
            end
        end
    endfunction

    task automatic cycle(input bit r, input bit v, input int ch, input int per, input bit en);
        logic [2*NCH-1:0] e;
        @(negedge clk);
        for (int i = 0; i < NCH; i++) if (ch_tick[i]) seen[i]++;
        rst        = r;
        cfg_valid  = v;
        cfg_ch     = CW'(ch);
        cfg_period = W'(per);
        cfg_enable = en;
        q_rdy.push_back(model_ready(ch));
        model_step(r, v, ch, per, en);
        for (int i = 0; i < NCH; i++) begin
            e[NCH+i] = m_tick[i];
            e[i]     = m_lvl[i];
        end
        q_out.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < NCH; i++) seen[i] = 0;
    endtask

    // Output monitor: registered outputs settle just after the rising edge
    initial begin
        logic [2*NCH-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q_out.size() > 0) begin
                e = q_out.pop_front();
                check("ch_tick", ch_tick, e[2*NCH-1:NCH]);
                check("ch_level", ch_level, e[NCH-1:0]);
            end
        end
    end

    // Ready monitor: combinational, checked after the stimulus edge
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            #1;
            if (q_rdy.size() > 0) begin
                e = q_rdy.pop_front();
                check("cfg_ready", cfg_ready, e);
            end
        end
    end

    initial begin
        model_reset();
        clear_seen();

        cycle(1, 0, 0, 0, 0);
        idle(200);
        check("idle_ticks", seen[0] + seen[1] + seen[2] + seen[3], 0);

        cycle(0, 1, 0, 2, 1);
        idle(5);
        clear_seen();
        idle(240);
        check("ch0_p2_ticks", seen[0], 20);

        cycle(0, 1, 1, 0, 1);
        idle(5);
        clear_seen();
        idle(240);
        check("ch1_p0_ticks", seen[1], 60);
        check("ch0_unchanged", seen[0], 20);

        idle(7);
        cycle(0, 1, 0, 5, 1);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 1, 1);
        idle(300);

        cycle(0, 1, 0, 3, 0);
        idle(200);
        clear_seen();
        idle(100);
        check("ch0_stopped", seen[0], 0);
        check("ch0_level_low", ch_level[0], 0);

        cycle(0, 1, 0, 7, 1);
        idle(10);
        cycle(0, 1, 0, 2, 1);
        idle(3);
        cycle(1, 0, 0, 0, 0);
        clear_seen();
        idle(100);
        check("post_rst_ticks", seen[0] + seen[1] + seen[2] + seen[3], 0);

        for (int k = 0; k < 20000; k++) begin
            bit r, v, en;
            int ch, per;
            r   = ($urandom_range(0, 999) == 0);
            v   = ($urandom_range(0, 9) == 0);
            ch  = $urandom_range(0, NCH - 1);
            per = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            en  = ($urandom_range(0, 3) != 0);
            cycle(r, v, ch, per, en);
        end

        @(posedge clk);
        #2;
        check("drain", q_out.size() + q_rdy.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
